// File: rtl/alu_seq.sv
// Multi-cycle ALU: one-hot ops plus shifts and an iterative MUL. Latency is 2 cycles for most ops
// and WIDTH+1 for MUL. Requests are taken only in IDLE; start while busy or in DONE is dropped.
module alu_seq #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [8:0]       command,
   input  logic [WIDTH-1:0] data1,
   input  logic [WIDTH-1:0] data2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] ALUresult,
   output logic             ALUzero,
   output logic             ALUneg,
   output logic             ALUcarry,
   output logic             ALUovf,
   output logic             ALUerr
);

   localparam logic [8:0] CMD_SUB = 9'h001;
   localparam logic [8:0] CMD_ADD = 9'h002;
   localparam logic [8:0] CMD_SL  = 9'h004;
   localparam logic [8:0] CMD_XOR = 9'h008;
   localparam logic [8:0] CMD_OR  = 9'h010;
   localparam logic [8:0] CMD_AND = 9'h020;
   localparam logic [8:0] CMD_SR  = 9'h040;
   localparam logic [8:0] CMD_SRA = 9'h080;
   localparam logic [8:0] CMD_MUL = 9'h100;

   localparam logic [WIDTH-1:0] RESET_VAL = {(WIDTH/4){4'h1}};
   localparam logic [SHW-1:0]   LAST_BIT  = SHW'(WIDTH-1);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      MUL,
      DONE
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [8:0]         cmd_q;
   logic [WIDTH-1:0]   op_a_q;
   logic [WIDTH-1:0]   op_b_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] mcand_q;
   logic [2*WIDTH-1:0] acc_d;
   logic [SHW-1:0]     bit_cnt_q;
   logic               mul_last;

   logic [WIDTH:0]     sum_w;
   logic [WIDTH:0]     diff_w;
   logic [SHW-1:0]     sh_amt;
   logic [WIDTH-1:0]   ex_res;
   logic               ex_carry;
   logic               ex_ovf;
   logic               ex_err;

   assign mul_last = (bit_cnt_q == LAST_BIT);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = (command == CMD_MUL) ? MUL : EXEC;
            end
         end
         EXEC: begin
            busy    = 1'b1;
            state_d = DONE;
         end
         MUL: begin
            busy = 1'b1;
            if (mul_last) begin
               state_d = DONE;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Single-cycle ops; the extra top bit of sum/diff is ADD carry-out and SUB borrow.
   assign sum_w  = {1'b0, op_a_q} + {1'b0, op_b_q};
   assign diff_w = {1'b0, op_a_q} - {1'b0, op_b_q};
   assign sh_amt = op_b_q[SHW-1:0];

   always_comb begin
      ex_res   = RESET_VAL;
      ex_carry = 1'b0;
      ex_ovf   = 1'b0;
      ex_err   = 1'b0;
      case (cmd_q)
         CMD_SUB: begin
            ex_res   = diff_w[WIDTH-1:0];
            ex_carry = diff_w[WIDTH];
            ex_ovf   = (op_a_q[WIDTH-1] != op_b_q[WIDTH-1]) &&
                       (diff_w[WIDTH-1] != op_a_q[WIDTH-1]);
         end
         CMD_ADD: begin
            ex_res   = sum_w[WIDTH-1:0];
            ex_carry = sum_w[WIDTH];
            ex_ovf   = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) &&
                       (sum_w[WIDTH-1] != op_a_q[WIDTH-1]);
         end
         CMD_SL:  ex_res = op_a_q << sh_amt;
         CMD_XOR: ex_res = op_a_q ^ op_b_q;
         CMD_OR:  ex_res = op_a_q | op_b_q;
         CMD_AND: ex_res = op_a_q & op_b_q;
         CMD_SR:  ex_res = op_a_q >> sh_amt;
         CMD_SRA: ex_res = $unsigned($signed(op_a_q) >>> sh_amt);
         // MUL never reaches EXEC, so anything else here is a malformed command.
         default: ex_err = 1'b1;
      endcase
   end

   // Shift-add step: multiplier bits are consumed LSB first out of op_b_q.
   assign acc_d = acc_q + (op_b_q[0] ? mcand_q : '0);

   always_ff @(posedge clock) begin
      if (reset) begin
         cmd_q     <= '0;
         op_a_q    <= '0;
         op_b_q    <= '0;
         acc_q     <= '0;
         mcand_q   <= '0;
         bit_cnt_q <= '0;
         ALUresult <= RESET_VAL;
         ALUzero   <= 1'b0;
         ALUneg    <= 1'b0;
         ALUcarry  <= 1'b0;
         ALUovf    <= 1'b0;
         ALUerr    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  cmd_q     <= command;
                  op_a_q    <= data1;
                  op_b_q    <= data2;
                  acc_q     <= '0;
                  mcand_q   <= {{WIDTH{1'b0}}, data1};
                  bit_cnt_q <= '0;
               end
            end
            EXEC: begin
               ALUresult <= ex_res;
               ALUzero   <= (ex_res == '0);
               ALUneg    <= ex_res[WIDTH-1];
               ALUcarry  <= ex_carry;
               ALUovf    <= ex_ovf;
               ALUerr    <= ex_err;
            end
            MUL: begin
               acc_q     <= acc_d;
               mcand_q   <= mcand_q << 1;
               op_b_q    <= op_b_q >> 1;
               bit_cnt_q <= bit_cnt_q + SHW'(1);
               if (mul_last) begin
                  ALUresult <= acc_d[WIDTH-1:0];
                  ALUzero   <= (acc_d[WIDTH-1:0] == '0);
                  ALUneg    <= acc_d[WIDTH-1];
                  ALUcarry  <= 1'b0;
                  ALUovf    <= |acc_d[2*WIDTH-1:WIDTH];
                  ALUerr    <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
